// File: rtl/stack_mc_controller_p.sv
// Multicycle control FSM for the stack-machine CPU. Adds memory wait states,
// stack-depth fault checking, a configurable opcode width and a retired-instruction counter.
module stack_mc_controller_p #(
  parameter int OPW    = 3,
  parameter int SDEPTH = 8,
  parameter int CW     = $clog2(SDEPTH + 1),
  parameter int RCW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             srcA,
  output logic             srcB,
  output logic             lda,
  output logic             ldb,
  output logic             PCsrc,
  output logic             PCwrite,
  output logic             PCwriteCond,
  output logic             IRwrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             mem_req,
  output logic             tos,
  output logic             pop,
  output logic             push,
  output logic             MtoS,
  output logic [1:0]       ALUop,
  output logic [CW-1:0]    sp_count,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic             retire,
  output logic [RCW-1:0]   retired_cnt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMRD, S_PUSHMEM, S_POPA, S_LOADA, S_MEMWR, S_POPB,
    S_LOADB, S_ALU, S_ALUNOT, S_PUSHRES, S_JUMP, S_BRANCH, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    sp_q, sp_d;
  logic [RCW-1:0]   rc_q, rc_d;
  logic [1:0]       fc_q, fc_d;
  logic [2:0]       op;
  logic             illegal;
  logic [1:0]       need_pops;

  assign op      = opcode[2:0];
  // Any set bit above the 3-bit opcode field makes the instruction illegal.
  assign illegal = (opcode >> 3) != '0;

  always_comb begin
    need_pops = 2'd0;
    case (op)
      3'b000, 3'b001, 3'b010: need_pops = 2'd2;
      3'b011, 3'b101:         need_pops = 2'd1;
      default:                need_pops = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    rc_d    = rc_q;
    fc_d    = fc_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (illegal) begin
          state_d = S_FAULT;
          fc_d    = 2'b11;
        end else if (CW'(need_pops) > sp_q) begin
          state_d = S_FAULT;
          fc_d    = 2'b01;
        end else if (op == 3'b100 && sp_q == CW'(SDEPTH)) begin
          state_d = S_FAULT;
          fc_d    = 2'b10;
        end else begin
          case (op)
            3'b100:  state_d = S_MEMRD;
            3'b110:  state_d = S_JUMP;
            3'b111:  state_d = S_BRANCH;
            default: state_d = S_POPA;
          endcase
        end
      end
      S_MEMRD:   if (mem_ready) state_d = S_PUSHMEM;
      S_PUSHMEM: begin
        sp_d    = sp_q + CW'(1);
        rc_d    = rc_q + RCW'(1);
        state_d = S_FETCH;
      end
      S_POPA: begin
        sp_d    = sp_q - CW'(1);
        state_d = S_LOADA;
      end
      S_LOADA: begin
        if (op == 3'b101)      state_d = S_MEMWR;
        else if (op == 3'b011) state_d = S_ALUNOT;
        else                   state_d = S_POPB;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          rc_d    = rc_q + RCW'(1);
          state_d = S_FETCH;
        end
      end
      S_POPB: begin
        sp_d    = sp_q - CW'(1);
        state_d = S_LOADB;
      end
      S_LOADB:   state_d = S_ALU;
      S_ALU:     state_d = S_PUSHRES;
      S_ALUNOT:  state_d = S_PUSHRES;
      S_PUSHRES: begin
        sp_d    = sp_q + CW'(1);
        rc_d    = rc_q + RCW'(1);
        state_d = S_FETCH;
      end
      S_JUMP, S_BRANCH: begin
        rc_d    = rc_q + RCW'(1);
        state_d = S_FETCH;
      end
      default:   state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      sp_q    <= '0;
      rc_q    <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      rc_q    <= rc_d;
      fc_q    <= fc_d;
    end
  end

  // Outputs decode from state (plus mem_ready in FETCH/MEMWR) so they track reset immediately.
  always_comb begin
    IorD = 1'b0; srcA = 1'b0; srcB = 1'b0; lda = 1'b0; ldb = 1'b0; PCsrc = 1'b0;
    PCwrite = 1'b0; PCwriteCond = 1'b0; IRwrite = 1'b0; memRead = 1'b0;
    memWrite = 1'b0; mem_req = 1'b0; tos = 1'b0; pop = 1'b0; push = 1'b0;
    MtoS = 1'b0; ALUop = 2'b00; retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1; mem_req = 1'b1;
        PCwrite = mem_ready; IRwrite = mem_ready;
      end
      S_DECODE:  tos = 1'b1;
      S_MEMRD:   begin IorD = 1'b1; memRead = 1'b1; mem_req = 1'b1; end
      S_PUSHMEM: begin MtoS = 1'b1; push = 1'b1; retire = 1'b1; end
      S_POPA, S_POPB: pop = 1'b1;
      S_LOADA:   lda = 1'b1;
      S_LOADB:   ldb = 1'b1;
      S_MEMWR:   begin IorD = 1'b1; memWrite = 1'b1; mem_req = 1'b1; retire = mem_ready; end
      S_ALU:     begin srcA = 1'b1; srcB = 1'b1; ALUop = op[1:0]; end
      S_ALUNOT:  begin srcA = 1'b1; ALUop = 2'b11; end
      S_PUSHRES: begin push = 1'b1; retire = 1'b1; end
      S_JUMP:    begin PCsrc = 1'b1; PCwrite = 1'b1; retire = 1'b1; end
      S_BRANCH:  begin PCsrc = 1'b1; PCwriteCond = 1'b1; retire = 1'b1; end
      default: ;
    endcase
  end

  assign sp_count    = sp_q;
  assign retired_cnt = rc_q;
  assign fault_code  = fc_q;
  assign fault       = (state_q == S_FAULT);

endmodule
